// File: rtl/aes_encrypt_round_sequencer.sv
// Round sequencer for a single-block AES encryption datapath.
// It drives the round index and the per-round datapath and key-schedule strobes.
module aes_encrypt_round_sequencer #(
  parameter int unsigned ROUND_W = 4,
  parameter int unsigned CNT_W   = 16,
  parameter bit          EN_256  = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         key_size,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROUND_W-1:0] round_idx,
  output logic               dp_init,
  output logic               dp_round,
  output logic               dp_mix,
  output logic               key_step,
  output logic               busy,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   blocks_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [ROUND_W-1:0] nr_r;
  logic [ROUND_W-1:0] nr_sel_s;
  logic               key_legal_s;

  // Decode the offered key size into a round count and a legality flag.
  always_comb begin
    nr_sel_s    = ROUND_W'(10);
    key_legal_s = 1'b0;
    case (key_size)
      2'b00: begin
        nr_sel_s    = ROUND_W'(10);
        key_legal_s = 1'b1;
      end
      2'b01: begin
        nr_sel_s    = ROUND_W'(12);
        key_legal_s = 1'b1;
      end
      2'b10: begin
        nr_sel_s    = ROUND_W'(14);
        key_legal_s = EN_256;
      end
      default: begin
        nr_sel_s    = ROUND_W'(10);
        key_legal_s = 1'b0;
      end
    endcase
  end

  // State, round index, registered strobes and the handoff counter.
  // The outputs are computed from the next state, so they line up with the state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r     <= S_IDLE;
      nr_r        <= ROUND_W'(10);
      round_idx   <= ROUND_W'(0);
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      dp_init     <= 1'b0;
      dp_round    <= 1'b0;
      dp_mix      <= 1'b0;
      key_step    <= 1'b0;
      err_pulse   <= 1'b0;
      blocks_done <= CNT_W'(0);
    end else begin
      dp_init   <= 1'b0;
      dp_round  <= 1'b0;
      dp_mix    <= 1'b0;
      key_step  <= 1'b0;
      err_pulse <= 1'b0;
      // Abort takes priority, even over an accept or an error in the same cycle.
      if (abort) begin
        state_r   <= S_IDLE;
        round_idx <= ROUND_W'(0);
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (in_valid && key_legal_s) begin
              state_r   <= S_INIT;
              nr_r      <= nr_sel_s;
              round_idx <= ROUND_W'(0);
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              dp_init   <= 1'b1;
              key_step  <= 1'b1;
            end else if (in_valid) begin
              err_pulse <= 1'b1;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_INIT: begin
            state_r   <= S_ROUND;
            round_idx <= ROUND_W'(1);
            dp_round  <= 1'b1;
            dp_mix    <= 1'b1;
            key_step  <= 1'b1;
          end
          S_ROUND: begin
            if (round_idx == nr_r - ROUND_W'(1)) begin
              state_r   <= S_FINAL;
              round_idx <= nr_r;
              dp_round  <= 1'b1;
            end else begin
              round_idx <= round_idx + ROUND_W'(1);
              dp_round  <= 1'b1;
              dp_mix    <= 1'b1;
              key_step  <= 1'b1;
            end
          end
          S_FINAL: begin
            state_r   <= S_DONE;
            out_valid <= 1'b1;
          end
          S_DONE: begin
            if (out_ready) begin
              state_r   <= S_IDLE;
              round_idx <= ROUND_W'(0);
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              if (blocks_done != {CNT_W{1'b1}}) begin
                blocks_done <= blocks_done + CNT_W'(1);
              end else begin
                blocks_done <= blocks_done;
              end
            end else begin
              state_r <= S_DONE;
            end
          end
          default: begin
            state_r   <= S_IDLE;
            round_idx <= ROUND_W'(0);
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_round_sequencer.sv
// Directed bench for aes_encrypt_round_sequencer.
// u0 uses the default parameters; u1 has 256-bit keys disabled and a 4-bit counter for the saturation check.
module tb_aes_encrypt_round_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_valid_b = 1'b0;
  logic [1:0] key_size = 2'b00;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, dp_init, dp_round, dp_mix, key_step, busy, err_pulse;
  logic [3:0]  round_idx;
  logic [15:0] blocks_done;

  logic        in_ready_b, out_valid_b, dp_init_b, dp_round_b, dp_mix_b, key_step_b, busy_b, err_pulse_b;
  logic [3:0]  round_idx_b;
  logic [3:0]  blocks_done_b;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_blocks = 16'd0;
  logic [11:0] obs;
  logic [11:0] exp_v;

  assign obs = {err_pulse, dp_init, dp_round, dp_mix, key_step, out_valid, in_ready, busy, round_idx};

  always #5 Clk = ~Clk;

  aes_encrypt_round_sequencer #(.ROUND_W(4), .CNT_W(16), .EN_256(1'b1)) u0 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .key_size(key_size),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .round_idx(round_idx),
    .dp_init(dp_init), .dp_round(dp_round), .dp_mix(dp_mix), .key_step(key_step),
    .busy(busy), .err_pulse(err_pulse), .blocks_done(blocks_done)
  );

  aes_encrypt_round_sequencer #(.ROUND_W(4), .CNT_W(4), .EN_256(1'b0)) u1 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .key_size(key_size),
    .abort(abort), .out_valid(out_valid_b), .out_ready(out_ready), .round_idx(round_idx_b),
    .dp_init(dp_init_b), .dp_round(dp_round_b), .dp_mix(dp_mix_b), .key_step(key_step_b),
    .busy(busy_b), .err_pulse(err_pulse_b), .blocks_done(blocks_done_b)
  );

  // Expected packed view: err, init, round, mix, key_step, out_valid, in_ready, busy, round_idx.
  function automatic logic [11:0] ex(input bit e, input bit i, input bit r, input bit m, input bit k,
                                     input bit ov, input bit ir, input bit b, input logic [3:0] idx);
    return {e, i, r, m, k, ov, ir, b, idx};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_block(input logic [1:0] ks, input int nr, input int hold);
    key_size = ks;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    key_size = 2'b11;
    exp_v = ex(0, 1, 0, 0, 1, 0, 0, 1, 4'd0);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL init ks=%0d got %h want %h", ks, obs, exp_v);
    end
    for (int r = 1; r < nr; r++) begin
      step();
      exp_v = ex(0, 0, 1, 1, 1, 0, 0, 1, 4'(r));
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL round%0d ks=%0d got %h want %h", r, ks, obs, exp_v);
      end
    end
    step();
    exp_v = ex(0, 0, 1, 0, 0, 0, 0, 1, 4'(nr));
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL final ks=%0d got %h want %h", ks, obs, exp_v);
    end
    step();
    exp_v = ex(0, 0, 0, 0, 0, 1, 0, 1, 4'(nr));
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL done ks=%0d got %h want %h", ks, obs, exp_v);
    end
    for (int h = 0; h < hold; h++) begin
      step();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL hold%0d got %h want %h", h, obs, exp_v);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (exp_blocks != 16'hFFFF) exp_blocks = exp_blocks + 16'd1;
    exp_v = ex(0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v || blocks_done !== exp_blocks) begin
      miscompares++;
      $display("FAIL handoff got %h/%0d want %h/%0d", obs, blocks_done, exp_v, exp_blocks);
    end
  endtask

  task automatic test_reset();
    #12;
    exp_v = ex(0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v || blocks_done !== 16'd0) begin
      miscompares++;
      $display("FAIL reset got %h/%0d want %h/0", obs, blocks_done, exp_v);
    end
    Rst = 1'b0;
    step();
  endtask

  task automatic test_key_sizes();
    run_block(2'b00, 10, 0);
    run_block(2'b01, 12, 0);
    run_block(2'b10, 14, 0);
  endtask

  task automatic test_illegal();
    key_size = 2'b11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_v = ex(1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL illegal_err got %h want %h", obs, exp_v);
    end
    step();
    exp_v = ex(0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v || blocks_done !== exp_blocks) begin
      miscompares++;
      $display("FAIL illegal_after got %h/%0d want %h/%0d", obs, blocks_done, exp_v, exp_blocks);
    end
    key_size = 2'b10;
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    vectors++;
    if (err_pulse_b !== 1'b1 || busy_b !== 1'b0 || in_ready_b !== 1'b1) begin
      miscompares++;
      $display("FAIL no256 got err=%b busy=%b rdy=%b want 1 0 1", err_pulse_b, busy_b, in_ready_b);
    end
  endtask

  task automatic test_backpressure();
    run_block(2'b00, 10, 20);
  endtask

  task automatic test_abort();
    int seen_ov;
    key_size = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    vectors++;
    if (round_idx !== 4'd5) begin
      miscompares++;
      $display("FAIL abort_pre round_idx got %0d want 5", round_idx);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_v = ex(0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL abort_idle got %h want %h", obs, exp_v);
    end
    seen_ov = 0;
    repeat (15) begin
      step();
      if (out_valid !== 1'b0) seen_ov++;
    end
    vectors++;
    if (seen_ov != 0 || blocks_done !== exp_blocks) begin
      miscompares++;
      $display("FAIL abort_quiet got ov_cycles=%0d blocks=%0d want 0/%0d", seen_ov, blocks_done, exp_blocks);
    end
    run_block(2'b00, 10, 0);
    key_size = 2'b01;
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL abort_accept got %h want %h", obs, exp_v);
    end
    key_size = 2'b11;
    step();
    in_valid = 1'b0;
    abort = 1'b0;
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL abort_err got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    key_size = 2'b01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2;
    Rst = 1'b1;
    #1;
    exp_blocks = 16'd0;
    exp_v = ex(0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    vectors++;
    if (obs !== exp_v || blocks_done !== exp_blocks) begin
      miscompares++;
      $display("FAIL async_rst got %h/%0d want %h/0", obs, blocks_done, exp_v);
    end
    #2;
    Rst = 1'b0;
    step();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL rst_release got %h want %h", obs, exp_v);
    end
    run_block(2'b01, 12, 0);
  endtask

  task automatic test_saturate();
    int n;
    logic [3:0] want;
    out_ready = 1'b1;
    key_size = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      in_valid_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      n = 0;
      while (in_ready_b !== 1'b1 && n < 30) begin
        step();
        n++;
      end
      want = (i > 15) ? 4'hF : 4'(i);
      vectors++;
      if (n >= 30 || blocks_done_b !== want) begin
        miscompares++;
        $display("FAIL saturate%0d got %0d want %0d (wait %0d)", i, blocks_done_b, want, n);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key_sizes();
    test_illegal();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
